// File: rtl/mem_stage.sv
// Memory-access stage: captures the EX instruction, aligns and extends load data,
// and forwards the packed result to WB and the bypass bus to ID.
module mem_stage #(
  parameter int CSR_BUS_W = 34
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 es2ms_valid,
  output logic                 ms_allowin,
  input  logic [31:0]          es_pc,
  input  logic [39:0]          es_rf_zip,
  input  logic [2:0]           es_ld_op,
  input  logic [CSR_BUS_W-1:0] es_csr_bus,
  input  logic [31:0]          data_sram_rdata,
  input  logic                 ws_allowin,
  input  logic                 flush,
  output logic                 ms2ws_valid,
  output logic [31:0]          ms_pc,
  output logic [38:0]          ms_rf_zip,
  output logic [CSR_BUS_W-1:0] ms_csr_bus,
  output logic [38:0]          ms_fwd_zip
);

  logic                 ms_valid;
  logic                 ms_ready_go;
  logic                 capture;
  logic                 first_p1;
  logic                 buf_vld_p1;
  logic [31:0]          rdata_buf_p1;
  logic [31:0]          pc_p1;
  logic                 csr_re_p1;
  logic                 res_from_mem_p1;
  logic                 rf_we_p1;
  logic [4:0]           rf_waddr_p1;
  logic [31:0]          alu_result_p1;
  logic [2:0]           ld_op_p1;
  logic [CSR_BUS_W-1:0] csr_bus_p1;
  logic [31:0]          rdata_eff;
  logic [31:0]          rf_wdata_pre;

  // Byte/half selection by address offset; unknown load types behave as ld.w.
  function automatic logic [31:0] load_extract(input logic [2:0]  op,
                                               input logic [1:0]  a,
                                               input logic [31:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      3'd1:    load_extract = 32'(b);
      3'd2:    load_extract = {24'd0, b};
      3'd3:    load_extract = 32'(h);
      3'd4:    load_extract = {16'd0, h};
      default: load_extract = rd;
    endcase
  endfunction

  assign ms_ready_go = 1'b1;
  assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms2ws_valid = ms_valid & ms_ready_go;
  assign capture     = es2ms_valid & ms_allowin;

  // EX -> MEM boundary: control and payload capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid        <= 1'b0;
      first_p1        <= 1'b0;
      buf_vld_p1      <= 1'b0;
      rdata_buf_p1    <= 32'd0;
      pc_p1           <= 32'd0;
      csr_re_p1       <= 1'b0;
      res_from_mem_p1 <= 1'b0;
      rf_we_p1        <= 1'b0;
      rf_waddr_p1     <= 5'd0;
      alu_result_p1   <= 32'd0;
      ld_op_p1        <= 3'd0;
      csr_bus_p1      <= '0;
    end else begin
      if (flush)           ms_valid <= 1'b0;
      else if (ms_allowin) ms_valid <= es2ms_valid;

      first_p1 <= capture;

      // SRAM output may drift during a stall, so hold the first-cycle word.
      if (flush || capture) begin
        buf_vld_p1 <= 1'b0;
      end else if (first_p1 && ms_valid && !ws_allowin) begin
        buf_vld_p1   <= 1'b1;
        rdata_buf_p1 <= data_sram_rdata;
      end

      if (capture) begin
        pc_p1           <= es_pc;
        csr_re_p1       <= es_rf_zip[39];
        res_from_mem_p1 <= es_rf_zip[38];
        rf_we_p1        <= es_rf_zip[37];
        rf_waddr_p1     <= es_rf_zip[36:32];
        alu_result_p1   <= es_rf_zip[31:0];
        ld_op_p1        <= es_ld_op;
        csr_bus_p1      <= es_csr_bus;
      end
    end
  end

  // MEM -> WB/ID boundary: result selection and output packing
  assign rdata_eff    = buf_vld_p1 ? rdata_buf_p1 : data_sram_rdata;
  assign rf_wdata_pre = res_from_mem_p1 ? load_extract(ld_op_p1, alu_result_p1[1:0], rdata_eff)
                                        : alu_result_p1;

  assign ms_pc      = pc_p1;
  assign ms_csr_bus = csr_bus_p1;
  assign ms_rf_zip  = {csr_re_p1, rf_we_p1, rf_waddr_p1, rf_wdata_pre};
  assign ms_fwd_zip = ms_valid ? {rf_we_p1, csr_re_p1, rf_waddr_p1, rf_wdata_pre} : 39'd0;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the 5-stage LoongArch CPU, sitting between the execute stage and the write-back stage. It accepts one instruction per cycle from EX over a valid/allowin handshake and receives the synchronous data-SRAM read data. For loads it extracts, aligns and sign/zero-extends the loaded value. It forwards a packed result bus to WB and a forwarding bus to ID.

## Interface
Parameters:
- CSR_BUS_W, 34, width of the opaque CSR side bus passed through to WB, carrying {ertn_flush, csr_we, csr_wmask/num...}.

Ports:
- clk  in  1  the single clock of the stage.
- reset  in  1  asynchronous, active-high reset.
- es2ms_valid  in  1  EX holds a valid instruction for MEM.
- ms_allowin  out  1  MEM can accept an instruction this cycle.
- es_pc  in  32  PC of the EX instruction.
- es_rf_zip  in  40  {csr_re, res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0]}.
- es_ld_op  in  3  load type: 000 ld.w, 001 ld.b, 010 ld.bu, 011 ld.h, 100 ld.hu, 101-111 treated as ld.w.
- es_csr_bus  in  CSR_BUS_W  CSR side bus, carried unmodified.
- data_sram_rdata  in  32  read data returned one cycle after EX issued the request.
- ws_allowin  in  1  WB can accept.
- flush  in  1  WB ertn/exception flush.
- ms2ws_valid  out  1  MEM presents a valid instruction to WB.
- ms_pc  out  32  registered PC.
- ms_rf_zip  out  39  {csr_re, rf_we, rf_waddr, rf_wdata_pre}.
- ms_csr_bus  out  CSR_BUS_W  registered es_csr_bus.
- ms_fwd_zip  out  39  {ms_valid & rf_we, csr_re, rf_waddr, rf_wdata_pre} for ID bypass/stall.

## Operation
- ms_ready_go = 1 always.
- ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
- ms2ws_valid = ms_valid & ms_ready_go.
- ms_valid updates in priority order:
  - reset → 0.
  - Else flush → 0. Flush overrides a simultaneous capture.
  - Else if ms_allowin, ms_valid ← es2ms_valid.
- Payload registers (pc, rf_zip fields, ld_op, csr_bus) load only when es2ms_valid & ms_allowin. They otherwise hold, including during stalls and flushes, and reset to 0.
- rdata hold buffer, needed because SRAM output is not guaranteed stable across a stall:
  - first flag: set on capture, cleared on the next clock edge.
  - While first=1 and ms_valid & ~ws_allowin: rdata_buf ← data_sram_rdata and buf_vld ← 1.
  - buf_vld clears on capture or flush.
  - Effective rdata = buf_vld ? rdata_buf : data_sram_rdata.
- Load extraction, with a = alu_result[1:0]:
  - byte = rdata[8a+7:8a].
  - half = a[1] ? rdata[31:16] : rdata[15:0].
  - ld.b/ld.h sign-extend; ld.bu/ld.hu zero-extend; ld.w uses rdata unmodified.
  - Misalignment is not checked here.
- rf_wdata_pre = res_from_mem ? load_data : alu_result.
- The rf_we field in ms_rf_zip is the raw registered bit. WB masks it with its own valid.
- ms_fwd_zip is masked by ms_valid. ID must stall rather than bypass when csr_re=1.

## Timing
- Latency: 1 cycle EX→WB when not stalled. An instruction captured at edge N is presented to WB during cycle N..N+1 and leaves at the next edge where ws_allowin=1.
- Stall (ws_allowin=0): all outputs hold, ms_allowin=0, and rdata is served from the buffer from the second cycle on.
- Back-to-back: an instruction leaves and a new one enters on the same edge when ms_valid & ws_allowin & es2ms_valid.
- Reset mid-operation: every register clears immediately (asynchronous). After reset:
  - ms2ws_valid=0, ms_allowin=1.
  - ms_pc=0, ms_rf_zip=0, ms_csr_bus=0, ms_fwd_zip=0.
- Flush and stall together: the instruction is dropped at the next edge. Outputs revert to invalid, and the payload values are don't-care.

## Test plan
- Reset asserted asynchronously mid-cycle → ms2ws_valid=0, ms_allowin=1, ms_fwd_zip=0 before the next edge.
- ld.b at addr[1:0]=2 with rdata=0x12_80_34_56 → wdata_pre=0xFFFFFF80. Same case with ld.bu → 0x00000080.
- ld.h at addr[1:0]=2 with rdata=0x8001_7FFF → 0xFFFF8001. ld.hu at addr[1:0]=0 → 0x00007FFF.
- Load captured, ws_allowin=0 for 3 cycles while data_sram_rdata changes to 0xDEADBEEF after the first cycle → delivered wdata equals the first-cycle data, and ms_pc and ms_rf_zip stay stable.
- ALU op (res_from_mem=0, alu_result=0x1234) followed back-to-back by a load with ws_allowin=1 → consecutive ms2ws_valid cycles with the correct pc and wdata each, and no bubble.
- flush asserted in the same cycle as es2ms_valid=1 → next cycle ms_valid=0 and ms_fwd_zip[38]=0.
